// File: rtl/corner_drain_arbiter.sv
// Round-robin drain of N showahead corner FIFOs into one 32-bit corner stream,
// with a per-frame corner cap and one trailer word carrying corner/drop counts per frame.
module corner_drain_arbiter #(
   parameter int unsigned N          = 4,
   parameter logic        CAM_ADDR   = 1'b0,
   parameter int unsigned MAX_QV     = 16383,
   parameter int unsigned DRAIN_WAIT = 8
) (
   input  logic            c,
   input  logic            rst,
   input  logic            en,
   input  logic            fv,
   input  logic [N*32-1:0] lane_q,
   input  logic [N-1:0]    lane_empty,
   output logic [N-1:0]    lane_rd,
   output logic [31:0]     q,
   output logic            qv,
   input  logic            q_rdy,
   output logic [15:0]     qv_cnt,
   output logic [7:0]      drop_cnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned WW = (DRAIN_WAIT > 0) ? $clog2(DRAIN_WAIT + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FLUSH,
      S_TRAILER
   } state_e;

   state_e         state_q, state_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           pend_q, pend_d;
   logic           fv_q;
   logic [31:0]    q_q, q_d;
   logic           qv_q, qv_d;
   logic [15:0]    qv_cnt_q, qv_cnt_d;
   logic [7:0]     drop_q, drop_d;

   logic [31:0]    lane_w [N];
   logic           fs, fe, slot_free, grant_en, grant, gnt_vld;
   logic [PW-1:0]  gnt_idx;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign lane_w[i] = lane_q[32*i +: 32];
   end

   assign fs        = fv & ~fv_q;
   assign fe        = ~fv & fv_q;
   assign slot_free = ~qv_q | q_rdy;
   assign grant_en  = slot_free & en &
                      ((state_q == S_RUN) | (state_q == S_DRAIN) | (state_q == S_FLUSH));
   assign grant     = grant_en & gnt_vld;
   assign lane_rd   = grant ? (N'(1) << gnt_idx) : '0;

   // First non-empty lane at or after ptr, wrapping modulo N
   always_comb begin
      int unsigned idx;
      idx     = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!gnt_vld && !lane_empty[PW'(idx)]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      wait_d   = wait_q;
      pend_d   = pend_q;
      q_d      = q_q;
      qv_d     = qv_q & ~q_rdy;
      qv_cnt_d = qv_cnt_q;
      drop_d   = drop_q;

      if (grant) begin
         ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
         if (qv_cnt_q < 16'(MAX_QV)) begin
            // Bits 30:29 are reserved so the trailer marker stays unique
            q_d      = lane_w[gnt_idx] & ~32'h6000_0000;
            qv_d     = 1'b1;
            qv_cnt_d = qv_cnt_q + 16'd1;
         end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (en && fs) begin
               state_d  = S_RUN;
               qv_cnt_d = '0;
               drop_d   = '0;
            end
         end
         S_RUN: begin
            if (fe) begin
               state_d = S_DRAIN;
               wait_d  = WW'(DRAIN_WAIT);
            end
         end
         S_DRAIN: begin
            if (fs) pend_d = 1'b1;
            if (wait_q == '0) state_d = S_FLUSH;
            else              wait_d  = wait_q - WW'(1);
         end
         S_FLUSH: begin
            if (fs) pend_d = 1'b1;
            if (&lane_empty && !grant) state_d = S_TRAILER;
         end
         S_TRAILER: begin
            if (fs) pend_d = 1'b1;
            if (slot_free && en) begin
               q_d  = {CAM_ADDR, 2'b11, 5'h00, drop_q, qv_cnt_q};
               qv_d = 1'b1;
               if (pend_q || fs) begin
                  // Next frame already open; if it has also ended, go straight to draining
                  state_d  = fv ? S_RUN : S_DRAIN;
                  wait_d   = WW'(DRAIN_WAIT);
                  qv_cnt_d = '0;
                  drop_d   = '0;
                  pend_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!en) begin
         state_d = S_IDLE;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         wait_q   <= '0;
         pend_q   <= 1'b0;
         fv_q     <= 1'b0;
         q_q      <= '0;
         qv_q     <= 1'b0;
         qv_cnt_q <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         wait_q   <= wait_d;
         pend_q   <= pend_d;
         fv_q     <= fv;
         q_q      <= q_d;
         qv_q     <= qv_d;
         qv_cnt_q <= qv_cnt_d;
         drop_q   <= drop_d;
      end
   end

   assign q        = q_q;
   assign qv       = qv_q;
   assign qv_cnt   = qv_cnt_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_corner_drain_arbiter.sv
// Directed bench for corner_drain_arbiter: FIFO lane models feed the DUT and a
// scoreboard queue holds every word (corners and trailers) expected on q in order.
module tb_corner_drain_arbiter;

   localparam int unsigned N      = 4;
   localparam int unsigned MAX_QV = 14;
   localparam int unsigned DW     = 8;

   logic            c = 1'b0;
   logic            rst, en, fv, q_rdy;
   logic [N*32-1:0] lane_q = '0;
   logic [N-1:0]    lane_empty = '1;
   logic [N-1:0]    lane_rd;
   logic [31:0]     q;
   logic            qv;
   logic [15:0]     qv_cnt;
   logic [7:0]      drop_cnt;

   logic [31:0] fifo [N][$];
   logic [31:0] sb [$];
   int checks = 0, passes = 0, fails = 0, pop_err = 0;

   corner_drain_arbiter #(.N(N), .CAM_ADDR(1'b0), .MAX_QV(MAX_QV), .DRAIN_WAIT(DW)) dut (
      .c(c), .rst(rst), .en(en), .fv(fv), .lane_q(lane_q), .lane_empty(lane_empty),
      .lane_rd(lane_rd), .q(q), .qv(qv), .q_rdy(q_rdy), .qv_cnt(qv_cnt), .drop_cnt(drop_cnt)
   );

   always #5 c = ~c;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cw(input int t, input int lane, input int idx);
      return {3'b000, 5'(lane), 8'(t), 16'(idx)};
   endfunction

   function automatic logic [31:0] trailer(input int drop, input int cnt);
      return {1'b0, 2'b11, 5'h00, 8'(drop), 16'(cnt)};
   endfunction

   task automatic push(input int lane, input logic [31:0] w, input bit fwd);
      fifo[lane].push_back(w);
      if (fwd) sb.push_back(w);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge c);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(posedge c);
         k++;
      end
      #1;
      check({tag, "_drained"}, 32'(sb.size()), 32'd0);
      tick(2);
   endtask

   // Showahead FIFO lane models: pop on lane_rd, heads visible from the next cycle
   always @(posedge c) begin
      logic [N*32-1:0] hq;
      logic [N-1:0]    he;
      for (int i = 0; i < N; i++) begin
         if (lane_rd[i]) begin
            if (fifo[i].size() > 0) void'(fifo[i].pop_front());
            else pop_err++;
         end
      end
      for (int i = 0; i < N; i++) begin
         he[i] = (fifo[i].size() == 0);
         hq[32*i +: 32] = he[i] ? 32'h0 : fifo[i][0];
      end
      lane_q     <= hq;
      lane_empty <= he;
   end

   // Output monitor: scoreboard compare on handshake, stability while stalled
   logic        hold_v = 1'b0;
   logic [31:0] hold_q = '0;
   always @(negedge c) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("qv_hold", 32'(qv), 32'd1);
            check("q_hold", q, hold_q);
         end
         if (qv && q_rdy) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $error("FAIL unexpected_word: observed %h expected none", q);
            end else begin
               check("q", q, sb.pop_front());
            end
         end
         hold_v = qv && !q_rdy;
         hold_q = q;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; fv = 1'b0; q_rdy = 1'b1;
      tick(3);
      check("rst_q", q, 32'h0);
      check("rst_qv", 32'(qv), 32'd0);
      check("rst_lane_rd", 32'(lane_rd), 32'd0);
      check("rst_qv_cnt", 32'(qv_cnt), 32'd0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b0; en = 1'b1;
      tick(2);

      // 1: empty frame still produces a trailer
      fv = 1'b1; tick(100); fv = 1'b0;
      sb.push_back(trailer(0, 0));
      wait_drain("t1", 40);
      check("t1_qv_cnt", 32'(qv_cnt), 32'd0);

      // 2: four full lanes drain in round-robin order
      for (int r = 0; r < 3; r++)
         for (int l = 0; l < 4; l++) push(l, cw(2, l, r), 1'b1);
      fv = 1'b1; tick(20); fv = 1'b0;
      sb.push_back(trailer(0, 12));
      wait_drain("t2", 60);
      check("t2_qv_cnt", 32'(qv_cnt), 32'd12);
      check("t2_drop_cnt", 32'(drop_cnt), 32'd0);

      // 3: single busy lane granted every cycle
      for (int i = 0; i < 5; i++) push(2, cw(3, 2, i), 1'b1);
      fv = 1'b1;
      @(posedge c);
      for (int i = 0; i < 5; i++) begin
         @(negedge c);
         check("t3_lane_rd", 32'(lane_rd), 32'h4);
      end
      @(negedge c);
      check("t3_lane_rd_done", 32'(lane_rd), 32'h0);
      @(posedge c); #1;
      fv = 1'b0;
      sb.push_back(trailer(0, 5));
      wait_drain("t3", 40);

      // 4: backpressure holds q and blocks grants
      q_rdy = 1'b0;
      for (int i = 0; i < 4; i++) push(1, cw(4, 1, i), 1'b1);
      fv = 1'b1; tick(2);
      for (int i = 0; i < 10; i++) begin
         @(negedge c);
         check("t4_lane_rd", 32'(lane_rd), 32'h0);
         check("t4_qv", 32'(qv), 32'd1);
         check("t4_q", q, cw(4, 1, 0));
      end
      @(posedge c); #1;
      q_rdy = 1'b1; fv = 1'b0;
      sb.push_back(trailer(0, 4));
      wait_drain("t4", 40);

      // 5: cap reached, last two corners popped and dropped
      for (int r = 0; r < 4; r++) begin
         push(2, cw(5, 2, r), (r * 4 + 0) < MAX_QV);
         push(3, cw(5, 3, r), (r * 4 + 1) < MAX_QV);
         push(0, cw(5, 0, r), (r * 4 + 2) < MAX_QV);
         push(1, cw(5, 1, r), (r * 4 + 3) < MAX_QV);
      end
      fv = 1'b1; tick(30); fv = 1'b0;
      sb.push_back(trailer(2, 14));
      wait_drain("t5", 40);
      check("t5_qv_cnt", 32'(qv_cnt), 32'd14);
      check("t5_drop_cnt", 32'(drop_cnt), 32'd2);
      check("t5_lanes_empty", 32'(fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size()), 32'd0);

      // 6: new frame starts during FLUSH, then reset mid-RUN
      q_rdy = 1'b0;
      for (int i = 0; i < 3; i++) push(0, cw(6, 0, i), 1'b1);
      fv = 1'b1; tick(3); fv = 1'b0; tick(20);
      fv = 1'b1; tick(2);
      sb.push_back(trailer(0, 3));
      q_rdy = 1'b1;
      wait_drain("t6a", 40);
      check("t6_new_qv_cnt", 32'(qv_cnt), 32'd0);
      check("t6_new_drop_cnt", 32'(drop_cnt), 32'd0);
      push(3, cw(6, 3, 0), 1'b1);
      push(3, cw(6, 3, 1), 1'b1);
      wait_drain("t6b", 20);
      check("t6_run_qv_cnt", 32'(qv_cnt), 32'd2);
      rst = 1'b1; fv = 1'b0;
      push(1, cw(6, 1, 9), 1'b0);
      @(negedge c);
      check("t6_rst_qv", 32'(qv), 32'd0);
      check("t6_rst_q", q, 32'h0);
      check("t6_rst_qv_cnt", 32'(qv_cnt), 32'd0);
      check("t6_rst_lane_rd", 32'(lane_rd), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(3);
      check("t6_idle_lane_rd", 32'(lane_rd), 32'h0);
      check("t6_idle_qv", 32'(qv), 32'd0);
      fifo[1].delete();

      check("pop_underflow", 32'(pop_err), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
